mem_copy_dma: RTL and testbench
===============================

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameters: ADDR_W, 15, memory address width; DATA_W, 8, memory data width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a transfer; sampled only in IDLE.
REQ-005 mode  input  1  0 = copy src->dst, 1 = fill dst with fill_value.
REQ-006 src_addr  input  ADDR_W  copy source base; latched on accepted start.
REQ-007 dst_addr  input  ADDR_W  destination base; latched on accepted start.
REQ-008 length  input  ADDR_W  byte count; latched on accepted start; 0 = no-op.
REQ-009 fill_value  input  DATA_W  fill byte; latched on accepted start.
REQ-010 mem_out  input  DATA_W  read data from memory; combinational from mem_address, same cycle.
REQ-011 mem_address  output  ADDR_W  memory address, registered.
REQ-012 mem_in  output  DATA_W  memory write data, registered.
REQ-013 mem_load  output  1  memory write enable, registered; memory writes on the rising edge where it is 1.
REQ-014 busy  output  1  high from the cycle after accepted start until DONE.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 States: IDLE, READ, WRITE, FILL, DONE.
REQ-017 IDLE: start=1 at edge -> latch inputs; remaining<=length, src_ptr<=src_addr, dst_ptr<=dst_addr.
REQ-018 Accepted start with length=0 -> DONE next cycle; mem_load stays 0, no memory access.
REQ-019 Accepted start, length>0, mode=0 -> READ; mem_address=src_addr, mem_load=0, busy=1.
REQ-020 READ (one cycle): at edge, capture mem_out; -> WRITE with mem_address=dst_ptr, mem_in=captured byte, mem_load=1.
REQ-021 WRITE (one cycle): at edge, byte written; src_ptr+1, dst_ptr+1, remaining-1; remaining becomes 0 -> DONE, mem_load=0; else -> READ, mem_address=new src_ptr, mem_load=0.
REQ-022 Copy of N bytes: 2N cycles in READ/WRITE, then 1 cycle DONE.
REQ-023 Accepted start, length>0, mode=1 -> FILL; mem_address=dst_addr, mem_in=fill_value, mem_load=1.
REQ-024 FILL: one byte per cycle; at each edge dst_ptr+1, remaining-1, mem_address follows; at remaining 0 -> DONE, mem_load=0. N bytes = N cycles.
REQ-025 DONE: done=1, busy=0, mem_load=0 for exactly one cycle, then -> IDLE.
REQ-026 start outside IDLE ignored, including in DONE; input changes after acceptance have no effect.
REQ-027 Pointers wrap modulo 2^ADDR_W (0x7FFF+1 = 0x0000); no error flag.
REQ-028 Copy is strictly forward, byte by byte; overlapping regions with dst>src replicate source bytes by design.
REQ-029 mem_load never high outside WRITE/FILL; exactly N write strobes per N-byte transfer.

Reset
REQ-030 reset=1 at an edge -> IDLE; mem_address=0, mem_in=0, mem_load=0, busy=0, done=0, internal pointers/counters 0.
REQ-031 reset has priority over start and mid-transfer state; transfer aborted, bytes already written remain, no done pulse.

Verification
REQ-032 Copy: mem[0x0010..0x0013]=11,22,33,44; start mode=0 src=0x0010 dst=0x0100 len=4 -> mem[0x0100..0x0103]=11,22,33,44; done one cycle after 8th transfer cycle; exactly 4 mem_load pulses.
REQ-033 Fill: mode=1 dst=0x7FFE len=4 fill=0xA5 -> 0x7FFE,0x7FFF,0x0000,0x0001 = 0xA5; 4 consecutive mem_load cycles; done next cycle.
REQ-034 Zero length: start len=0 -> done pulse next cycle; mem_load never 1; busy never 1.
REQ-035 Start while busy: second start with different dst during 4-byte copy -> ignored; only first destination written.
REQ-036 Reset mid-copy: reset after 2nd WRITE of 4-byte copy -> next cycle all outputs 0, IDLE; dst bytes 0,1 written, 2,3 unchanged; no done.
REQ-037 Overlap: mem[0x20]=0x5A, copy src=0x20 dst=0x21 len=3 -> mem[0x21..0x23]=0x5A.

Source files
------------

// File: rtl/mem_copy_dma.sv
// Byte-wise memory copy/fill engine driving a single-port memory with
// combinational read data. Copy alternates READ/WRITE per byte; fill writes one byte per cycle.
module mem_copy_dma #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, FILL, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
      mem_address <= '0;
      mem_in      <= '0;
      mem_load    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= length;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (mode) begin
              state       <= FILL;
              mem_address <= dst_addr;
              mem_in      <= fill_value;
              mem_load    <= 1'b1;
              busy        <= 1'b1;
            end else begin
              state       <= READ;
              mem_address <= src_addr;
              mem_load    <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        READ: begin
          // mem_out already reflects src_ptr; present it for the write cycle
          mem_in      <= mem_out;
          mem_address <= dst_ptr;
          mem_load    <= 1'b1;
          state       <= WRITE;
        end
        WRITE: begin
          src_ptr   <= src_ptr + 1'b1;
          dst_ptr   <= dst_ptr + 1'b1;
          remaining <= remaining - 1'b1;
          mem_load  <= 1'b0;
          if (remaining == ADDR_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state       <= READ;
            mem_address <= src_ptr + 1'b1;
          end
        end
        FILL: begin
          dst_ptr     <= dst_ptr + 1'b1;
          remaining   <= remaining - 1'b1;
          mem_address <= dst_ptr + 1'b1;
          if (remaining == ADDR_W'(1)) begin
            state    <= DONE;
            mem_load <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: behavioural 32K x 8 memory, per-scenario tasks.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [14:0] src_addr;
  logic [14:0] dst_addr;
  logic [14:0] length;
  logic [7:0]  fill_value;
  logic [7:0]  mem_out;
  logic [14:0] mem_address;
  logic [7:0]  mem_in;
  logic        mem_load;
  logic        busy;
  logic        done;

  logic [7:0] mem [0:32767];
  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  mem_copy_dma #(.ADDR_W(15), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .mem_out(mem_out), .mem_address(mem_address),
    .mem_in(mem_in), .mem_load(mem_load), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign mem_out = mem[mem_address];

  always @(posedge clk) begin
    if (mem_load) begin
      mem[mem_address] = mem_in;
      load_cnt = load_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic kick(input logic m, input logic [14:0] s, input logic [14:0] d,
                      input logic [14:0] n, input logic [7:0] f);
    @(negedge clk);
    load_cnt = 0; done_cnt = 0; busy_cnt = 0;
    mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f;
    start = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = 15'h0; dst_addr = 15'h0; length = 15'h0; fill_value = 8'h0;
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    checks += 5;
    if (mem_address !== 15'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_address); end
    if (mem_in !== 8'h0) begin errors++; $display("FAIL reset_mem_in got %h want 0", mem_in); end
    if (mem_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", mem_load); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_copy;
    int cyc;
    mem[15'h10] = 8'h11; mem[15'h11] = 8'h22; mem[15'h12] = 8'h33; mem[15'h13] = 8'h44;
    kick(1'b0, 15'h0010, 15'h0100, 15'd4, 8'h00);
    @(negedge clk); start = 1'b0; cyc = 1;
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL copy_busy got %b want 1", busy); end
    if (mem_address !== 15'h0010) begin errors++; $display("FAIL copy_rd_addr got %h want 0010", mem_address); end
    if (mem_load !== 1'b0) begin errors++; $display("FAIL copy_rd_load got %b want 0", mem_load); end
    @(negedge clk); cyc++;
    checks += 3;
    if (mem_address !== 15'h0100) begin errors++; $display("FAIL copy_wr_addr got %h want 0100", mem_address); end
    if (mem_in !== 8'h11) begin errors++; $display("FAIL copy_wr_data got %h want 11", mem_in); end
    if (mem_load !== 1'b1) begin errors++; $display("FAIL copy_wr_load got %b want 1", mem_load); end
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks += 4;
    if (cyc !== 9) begin errors++; $display("FAIL copy_done_cycle got %0d want 9", cyc); end
    if (busy !== 1'b0) begin errors++; $display("FAIL copy_busy_at_done got %b want 0", busy); end
    if (load_cnt !== 4) begin errors++; $display("FAIL copy_loads got %0d want 4", load_cnt); end
    if ({mem[15'h100], mem[15'h101], mem[15'h102], mem[15'h103]} !== 32'h11223344) begin
      errors++; $display("FAIL copy_data got %h%h%h%h want 11223344",
                         mem[15'h100], mem[15'h101], mem[15'h102], mem[15'h103]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL copy_done_width got %b want 0", done); end
  endtask

  task automatic test_fill;
    int cyc;
    kick(1'b1, 15'h0000, 15'h7FFE, 15'd4, 8'hA5);
    @(negedge clk); start = 1'b0; cyc = 1;
    checks += 3;
    if (mem_address !== 15'h7FFE) begin errors++; $display("FAIL fill_addr got %h want 7FFE", mem_address); end
    if (mem_in !== 8'hA5) begin errors++; $display("FAIL fill_data got %h want A5", mem_in); end
    if (mem_load !== 1'b1) begin errors++; $display("FAIL fill_load got %b want 1", mem_load); end
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks += 4;
    if (cyc !== 5) begin errors++; $display("FAIL fill_done_cycle got %0d want 5", cyc); end
    if (load_cnt !== 4) begin errors++; $display("FAIL fill_loads got %0d want 4", load_cnt); end
    if ({mem[15'h7FFE], mem[15'h7FFF], mem[15'h0000], mem[15'h0001]} !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL fill_wrap_data got %h%h%h%h want A5A5A5A5",
                         mem[15'h7FFE], mem[15'h7FFF], mem[15'h0000], mem[15'h0001]);
    end
    if (mem[15'h7FFD] !== 8'h00 || mem[15'h0002] !== 8'h00) begin
      errors++; $display("FAIL fill_bounds got %h %h want 00 00", mem[15'h7FFD], mem[15'h0002]);
    end
  endtask

  task automatic test_zero_len;
    kick(1'b0, 15'h0010, 15'h0500, 15'd0, 8'h00);
    @(negedge clk); start = 1'b0;
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    checks += 3;
    if (load_cnt !== 0) begin errors++; $display("FAIL zero_loads got %0d want 0", load_cnt); end
    if (busy_cnt !== 0) begin errors++; $display("FAIL zero_busy_cycles got %0d want 0", busy_cnt); end
    if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    kick(1'b0, 15'h0010, 15'h0200, 15'd4, 8'h00);
    @(negedge clk); start = 1'b0; cyc = 1;
    @(negedge clk); cyc++;
    dst_addr = 15'h0300; length = 15'd2; start = 1'b1;
    @(negedge clk); cyc++; start = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    // a start held during DONE must also be dropped
    mode = 1'b1; fill_value = 8'hEE; dst_addr = 15'h0300; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_start_busy got %b want 0", busy); end
    if (mem_load !== 1'b0) begin errors++; $display("FAIL done_start_load got %b want 0", mem_load); end
    repeat (4) @(negedge clk);
    checks += 3;
    if ({mem[15'h200], mem[15'h201], mem[15'h202], mem[15'h203]} !== 32'h11223344) begin
      errors++; $display("FAIL busy_start_data got %h%h%h%h want 11223344",
                         mem[15'h200], mem[15'h201], mem[15'h202], mem[15'h203]);
    end
    if (mem[15'h300] !== 8'h00 || mem[15'h301] !== 8'h00) begin
      errors++; $display("FAIL busy_start_dst2 got %h %h want 00 00", mem[15'h300], mem[15'h301]);
    end
    if (load_cnt !== 4) begin errors++; $display("FAIL busy_start_loads got %0d want 4", load_cnt); end
  endtask

  task automatic test_reset_mid;
    kick(1'b0, 15'h0010, 15'h0400, 15'd4, 8'h00);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks += 4;
    if (mem_address !== 15'h0 || mem_in !== 8'h0) begin
      errors++; $display("FAIL abort_data_regs got %h %h want 0 0", mem_address, mem_in);
    end
    if (mem_load !== 1'b0) begin errors++; $display("FAIL abort_load got %b want 0", mem_load); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    repeat (10) @(negedge clk);
    checks += 3;
    if (done_cnt !== 0) begin errors++; $display("FAIL abort_done_pulses got %0d want 0", done_cnt); end
    if (load_cnt !== 2) begin errors++; $display("FAIL abort_loads got %0d want 2", load_cnt); end
    if ({mem[15'h400], mem[15'h401], mem[15'h402], mem[15'h403]} !== 32'h11220000) begin
      errors++; $display("FAIL abort_data got %h%h%h%h want 11220000",
                         mem[15'h400], mem[15'h401], mem[15'h402], mem[15'h403]);
    end
  endtask

  task automatic test_overlap;
    int cyc;
    mem[15'h20] = 8'h5A;
    kick(1'b0, 15'h0020, 15'h0021, 15'd3, 8'h00);
    @(negedge clk); start = 1'b0; cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks += 2;
    if (cyc !== 7) begin errors++; $display("FAIL overlap_done_cycle got %0d want 7", cyc); end
    if ({mem[15'h21], mem[15'h22], mem[15'h23], mem[15'h24]} !== 32'h5A5A5A00) begin
      errors++; $display("FAIL overlap_data got %h%h%h%h want 5A5A5A00",
                         mem[15'h21], mem[15'h22], mem[15'h23], mem[15'h24]);
    end
  endtask

  initial begin
    test_reset;
    test_copy;
    test_fill;
    test_zero_len;
    test_back_to_back;
    test_reset_mid;
    test_overlap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
